// File: rtl/cache_arb_if.sv
// Request, release and grant signals between the cache pipeline stages and the
// array arbiter; the stages drive the master side, the arbiter owns the slave side.
interface cache_arb_if;
    logic info_req;
    logic rplc_req;
    logic rsp_req;
    logic info_done;
    logic rplc_done;
    logic rsp_done;
    logic info_arb;
    logic rplc_arb;
    logic rsp_arb;
    logic arb_busy;
    logic info_starved;

    modport master (
        output info_req, rplc_req, rsp_req, info_done, rplc_done, rsp_done,
        input  info_arb, rplc_arb, rsp_arb, arb_busy, info_starved
    );

    modport slave (
        input  info_req, rplc_req, rsp_req, info_done, rplc_done, rsp_done,
        output info_arb, rplc_arb, rsp_arb, arb_busy, info_starved
    );
endinterface

// File: rtl/cache_arb_ctrl.sv
// Held-grant arbiter for the shared cache arrays (rplc > rsp > info), one-hot registered selects.
// Optional info starvation guard is compiled in when CACHE_ARB_STARVE_EN is defined.
module cache_arb_ctrl #(
    parameter int STARVE_LIMIT = 15,
    parameter int STARVE_W     = 4
) (
    input  logic       clk,
    input  logic       rst,
    cache_arb_if.slave arb
);
    typedef enum logic [1:0] {IDLE, G_INFO, G_RPLC, G_RSP} state_t;

    if (2 ** STARVE_W <= STARVE_LIMIT) begin : g_cfg_check
        $error("cache_arb_ctrl: STARVE_W too narrow to hold STARVE_LIMIT");
    end

    state_t state_q, state_d;
    logic   info_arb_q, rplc_arb_q, rsp_arb_q, busy_q;
    logic   promote;
    logic   owner_release;
    logic   cand_info, cand_rplc, cand_rsp;

    // The releasing owner is masked out so it cannot re-grant itself without an idle gap.
    always_comb begin
        owner_release = 1'b0;
        cand_info     = arb.info_req;
        cand_rplc     = arb.rplc_req;
        cand_rsp      = arb.rsp_req;
        case (state_q)
            G_INFO: begin
                owner_release = arb.info_done | ~arb.info_req;
                cand_info     = 1'b0;
            end
            G_RPLC: begin
                owner_release = arb.rplc_done | ~arb.rplc_req;
                cand_rplc     = 1'b0;
            end
            G_RSP: begin
                owner_release = arb.rsp_done | ~arb.rsp_req;
                cand_rsp      = 1'b0;
            end
            default: ;
        endcase

        state_d = state_q;
        if (state_q == IDLE || owner_release) begin
            if (promote && cand_info) state_d = G_INFO;
            else if (cand_rplc)       state_d = G_RPLC;
            else if (cand_rsp)        state_d = G_RSP;
            else if (cand_info)       state_d = G_INFO;
            else                      state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            info_arb_q <= 1'b0;
            rplc_arb_q <= 1'b0;
            rsp_arb_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            info_arb_q <= (state_d == G_INFO);
            rplc_arb_q <= (state_d == G_RPLC);
            rsp_arb_q  <= (state_d == G_RSP);
            busy_q     <= (state_d != IDLE);
        end
    end

`ifdef CACHE_ARB_STARVE_EN
    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                starved_q, starved_d;

    // Counts cycles info waits with a live request; the flag follows one cycle after saturation.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!arb.info_req || info_arb_q)
            wait_cnt_d = '0;
        else if (wait_cnt_q != LIMIT)
            wait_cnt_d = wait_cnt_q + 1'b1;
        starved_d = (state_d != G_INFO) && arb.info_req && (wait_cnt_q == LIMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
            starved_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            starved_q  <= starved_d;
        end
    end

    assign promote = starved_q;
`else
    assign promote = 1'b0;
`endif

    assign arb.info_arb     = info_arb_q;
    assign arb.rplc_arb     = rplc_arb_q;
    assign arb.rsp_arb      = rsp_arb_q;
    assign arb.arb_busy     = busy_q;
    assign arb.info_starved = promote;
endmodule

// File: tb/tb_cache_arb_ctrl.sv
// Self-checking bench for cache_arb_ctrl: directed scenarios plus a randomized run
// against an owner/priority-list reference model. Honors CACHE_ARB_STARVE_EN.
module tb_cache_arb_ctrl;
    localparam int LIMIT = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_arb_if bus ();

    cache_arb_ctrl #(.STARVE_LIMIT(LIMIT), .STARVE_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .arb (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit onehot_on = 1'b0;

    // Reference model: who owns the array (0 none, 1 info, 2 rplc, 3 rsp), how long info waited.
    int own      = 0;
    int wait_n   = 0;
    bit starved_m = 1'b0;
    bit m_req  [1:3];
    bit m_done [1:3];

    function automatic logic [4:0] outs();
        return {bus.info_arb, bus.rplc_arb, bus.rsp_arb, bus.arb_busy, bus.info_starved};
    endfunction

    function automatic logic [4:0] model_outs();
        return {own == 1, own == 2, own == 3, own != 0, starved_m};
    endfunction

    task automatic model_edge();
        int nxt;
        int order [3];
        bit rel;
        bit nst;
        order = '{2, 3, 1};
        if (rst) begin
            own = 0; wait_n = 0; starved_m = 1'b0;
            return;
        end
        rel = (own != 0) && (m_done[own] || !m_req[own]);
        nxt = own;
        if (own == 0 || rel) begin
            nxt = 0;
            if (starved_m && m_req[1] && own != 1) nxt = 1;
            else
                foreach (order[k])
                    if (nxt == 0 && m_req[order[k]] && order[k] != own) nxt = order[k];
        end
`ifdef CACHE_ARB_STARVE_EN
        nst    = (nxt != 1) && m_req[1] && (wait_n == LIMIT);
        wait_n = (m_req[1] && own != 1) ? ((wait_n < LIMIT) ? wait_n + 1 : LIMIT) : 0;
        starved_m = nst;
`else
        nst = 1'b0;
        starved_m = nst;
`endif
        own = nxt;
    endtask

    task automatic drive(input bit ri, input bit rr, input bit rs,
                         input bit di, input bit dr, input bit ds);
        bus.info_req  = ri; bus.rplc_req  = rr; bus.rsp_req  = rs;
        bus.info_done = di; bus.rplc_done = dr; bus.rsp_done = ds;
        m_req[1] = ri;  m_req[2] = rr;  m_req[3] = rs;
        m_done[1] = di; m_done[2] = dr; m_done[3] = ds;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Invariant: never more than one grant, checked every cycle of every test.
    always @(negedge clk) begin
        if (onehot_on) begin
            n_checks++;
            if ($countones({bus.info_arb, bus.rplc_arb, bus.rsp_arb}) > 1)
                $display("FAIL onehot: grants=%b required at most one high",
                         {bus.info_arb, bus.rplc_arb, bus.rsp_arb});
            else n_pass++;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (outs() !== 5'b00000) $display("FAIL reset_hold: got %b required 00000", outs());
            else n_pass++;
        end
        onehot_on = 1'b1;
        rst = 1'b0;
        step();
        n_checks++;
        if (outs() !== 5'b01010) $display("FAIL reset_release: got %b required 01010", outs());
        else n_pass++;
        rst = 1'b1;
        step();
        n_checks++;
        if (outs() !== 5'b00000) $display("FAIL reset_midgrant: got %b required 00000", outs());
        else n_pass++;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        step();
        $display("test_reset done");
    endtask

    task automatic test_simultaneous();
        drive(1, 1, 1, 0, 0, 0);
        step();
        n_checks++;
        if (outs() !== 5'b01010) $display("FAIL simul_rplc: got %b required 01010", outs());
        else n_pass++;
        step();
        drive(1, 0, 1, 0, 1, 0);
        step();
        n_checks++;
        if (outs() !== 5'b00110) $display("FAIL simul_rsp: got %b required 00110", outs());
        else n_pass++;
        drive(1, 0, 0, 0, 0, 1);
        step();
        n_checks++;
        if (outs() !== 5'b10010) $display("FAIL simul_info: got %b required 10010", outs());
        else n_pass++;
        drive(1, 0, 0, 1, 0, 0);
        step();
        n_checks++;
        if (outs() !== 5'b00000) $display("FAIL done_with_req_idle: got %b required 00000", outs());
        else n_pass++;
        drive(1, 0, 0, 0, 0, 0);
        step();
        n_checks++;
        if (outs() !== 5'b10010) $display("FAIL rearbitrate: got %b required 10010", outs());
        else n_pass++;
        drive(0, 0, 0, 0, 0, 0);
        step();
        $display("test_simultaneous done");
    endtask

    task automatic test_no_preempt();
        drive(1, 0, 0, 0, 0, 0);
        step();
        drive(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (outs() !== 5'b10010) $display("FAIL no_preempt[%0d]: got %b required 10010", i, outs());
            else n_pass++;
        end
        drive(0, 1, 0, 1, 0, 0);
        step();
        n_checks++;
        if (outs() !== 5'b01010) $display("FAIL handoff_rplc: got %b required 01010", outs());
        else n_pass++;
        drive(0, 0, 0, 0, 0, 0);
        step();
        $display("test_no_preempt done");
    endtask

    task automatic test_abort();
        drive(0, 0, 1, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        step();
        n_checks++;
        if (outs() !== 5'b00000) $display("FAIL abort_idle: got %b required 00000", outs());
        else n_pass++;
        drive(0, 1, 0, 0, 0, 0);
        step();
        drive(1, 1, 1, 1, 0, 1);
        step();
        n_checks++;
        if (outs() !== 5'b01010) $display("FAIL ignored_done: got %b required 01010", outs());
        else n_pass++;
        drive(0, 0, 0, 0, 0, 0);
        step();
        n_checks++;
        if (outs() !== 5'b00000) $display("FAIL abort_release: got %b required 00000", outs());
        else n_pass++;
        $display("test_abort done");
    endtask

    // rplc and rsp keep requesting and each releases on its second granted cycle.
    task automatic test_starvation();
        int age = 0, prev = 0, cur, rise = -1, info_at = -1;
`ifdef CACHE_ARB_STARVE_EN
        for (int c = 1; c <= 60 && info_at < 0; c++) begin
            cur = bus.rplc_arb ? 2 : bus.rsp_arb ? 3 : bus.info_arb ? 1 : 0;
            age = (cur == prev) ? age + 1 : 1;
            prev = cur;
            drive(1, 1, 1, 0, cur == 2 && age >= 2, cur == 3 && age >= 2);
            step();
            if (bus.info_starved && rise < 0) rise = c;
            if (bus.info_arb) info_at = c;
        end
        n_checks++;
        if (rise !== LIMIT + 1) $display("FAIL starve_rise: got cycle %0d required %0d", rise, LIMIT + 1);
        else n_pass++;
        n_checks++;
        if (info_at < 0 || info_at <= rise) $display("FAIL starve_grant: got cycle %0d required after %0d", info_at, rise);
        else n_pass++;
        n_checks++;
        if (outs() !== 5'b10010) $display("FAIL starve_clear: got %b required 10010", outs());
        else n_pass++;
`else
        for (int c = 1; c <= 100; c++) begin
            cur = bus.rplc_arb ? 2 : bus.rsp_arb ? 3 : bus.info_arb ? 1 : 0;
            age = (cur == prev) ? age + 1 : 1;
            prev = cur;
            drive(1, 1, 1, 0, cur == 2 && age >= 2, cur == 3 && age >= 2);
            step();
            n_checks++;
            if (bus.info_arb !== 1'b0 || bus.info_starved !== 1'b0)
                $display("FAIL strict_priority c%0d: info_arb=%b starved=%b required 0/0",
                         c, bus.info_arb, bus.info_starved);
            else n_pass++;
        end
        rise = info_at;
`endif
        drive(0, 0, 0, 0, 0, 0);
        step();
        step();
        $display("test_starvation done");
    endtask

    task automatic test_random();
        logic [4:0] exp;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(59) == 0);
            drive($urandom_range(9) < 6, $urandom_range(9) < 4, $urandom_range(9) < 4,
                  $urandom_range(9) < 3, $urandom_range(9) < 3, $urandom_range(9) < 3);
            step();
            exp = model_outs();
            n_checks++;
            if (outs() !== exp) $display("FAIL random[%0d]: got %b required %b", i, outs(), exp);
            else n_pass++;
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        step();
        $display("test_random done");
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        test_reset();
        test_simultaneous();
        test_no_preempt();
        test_abort();
        test_starvation();
        test_random();
        onehot_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
